audio_dac_serializer: RTL and testbench

Serializes the 16-bit mono audio sample produced by the send/receive sound controllers into an I2S bit stream for the board audio codec DAC. It generates the codec bit clock and left/right clock from `FPGA_clock`, samples the upstream sample word once per frame, and applies mute and a power-of-two attenuation. It sits directly downstream of the sound controllers' `*_audio_output` buses and drives the codec pins.

---
 rtl/audio_dac_serializer_if.sv | 21 ++
 rtl/audio_dac_serializer.sv | 62 ++++++
 tb/tb_audio_dac_serializer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/audio_dac_serializer_if.sv
// audio_dac_serializer_if: bundles the sample inputs and codec pin outputs of the I2S DAC serializer.
//   sample_in[15:0]   two's-complement mono sample from the sound controller
//   volume_shift[2:0] arithmetic right shift applied at the frame latch
//   mute              zero the latched word
//   AUD_BCLK          codec bit clock
//   AUD_DACLRCK       0 = left half of frame, 1 = right half
//   AUD_DACDAT        serial data, MSB first, I2S framing
//   frame_tick        one-cycle pulse when a new word is latched
interface audio_dac_serializer_if;
    logic [15:0] sample_in;
    logic [2:0]  volume_shift;
    logic        mute;
    logic        AUD_BCLK;
    logic        AUD_DACLRCK;
    logic        AUD_DACDAT;
    logic        frame_tick;
    modport master (output sample_in, volume_shift, mute,
                    input AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, frame_tick);
    modport slave (input sample_in, volume_shift, mute,
                   output AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, frame_tick);
endinterface

// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer: I2S serializer for the board codec DAC, mono sample duplicated on both channels.
//   FPGA_clock  system clock, rising edge
//   resetn      asynchronous active-low reset
//   aud         slave side of audio_dac_serializer_if (sample/volume/mute in, codec pins and frame_tick out)
//   BCLK_HALF   FPGA_clock cycles per half BCLK period (>= 2)
module audio_dac_serializer #(
    parameter int BCLK_HALF = 8
) (
    input logic                   FPGA_clock,
    input logic                   resetn,
    audio_dac_serializer_if.slave aud
);
    localparam int DW = $clog2(BCLK_HALF);
    localparam logic [DW-1:0] DIV_MAX = DW'(BCLK_HALF - 1);
    logic [DW-1:0] div_q, div_d;
    logic [5:0]    slot_q, slot_d, slot_n;
    logic [15:0]   word_q, word_d, scaled;
    logic          bclk_q, bclk_d, lrck_q, lrck_d, dat_q, dat_d, tick_q, tick_d;
    logic          tc, fall, latch;
    logic [4:0]    j;
    logic [3:0]    idx;
    always_comb begin
        tc     = div_q == DIV_MAX;
        fall   = tc && bclk_q;
        slot_n = slot_q + 6'd1;
        latch  = fall && slot_n == 6'd0;
        j      = slot_n[4:0];
        // data slot j carries word bit 16-j; slot 0 is the I2S one-bit delay
        idx    = 4'(5'd16 - j);
        scaled = 16'($signed(aud.sample_in) >>> aud.volume_shift);
        div_d  = tc ? '0 : div_q + DW'(1);
        bclk_d = bclk_q ^ tc;
        slot_d = fall ? slot_n : slot_q;
        lrck_d = fall ? slot_n[5] : lrck_q;
        dat_d  = fall ? (j >= 5'd1 && j <= 5'd16 && word_q[idx]) : dat_q;
        word_d = latch ? (aud.mute ? '0 : scaled) : word_q;
        tick_d = latch;
    end
    always_ff @(posedge FPGA_clock or negedge resetn) begin
        if (!resetn) begin
            div_q  <= '0;
            slot_q <= '0;
            word_q <= '0;
            bclk_q <= 1'b0;
            lrck_q <= 1'b0;
            dat_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            slot_q <= slot_d;
            word_q <= word_d;
            bclk_q <= bclk_d;
            lrck_q <= lrck_d;
            dat_q  <= dat_d;
            tick_q <= tick_d;
        end
    end
    assign aud.AUD_BCLK    = bclk_q;
    assign aud.AUD_DACLRCK = lrck_q;
    assign aud.AUD_DACDAT  = dat_q;
    assign aud.frame_tick  = tick_q;
endmodule

// File: tb/tb_audio_dac_serializer.sv
// tb_audio_dac_serializer: directed scoreboard bench for the I2S DAC serializer.
module tb_audio_dac_serializer;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int total = 0;
    int bad = 0;
    logic [15:0] exp_q[$];
    audio_dac_serializer_if aif();
    audio_dac_serializer #(.BCLK_HALF(8)) dut (
        .FPGA_clock(clk),
        .resetn(resetn),
        .aud(aif.slave)
    );
    always #5 clk = ~clk;

    function automatic logic [15:0] atten(input logic [15:0] s, input logic [2:0] v, input logic m);
        logic signed [15:0] ss;
        ss = s;
        return m ? 16'h0000 : 16'(ss >>> v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        total++;
        bad++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic wait_bclk(input logic v);
        for (int i = 0; i < 100; i++) begin
            if (aif.AUD_BCLK === v) return;
            @(posedge clk);
            #1;
        end
        timeout("bclk_wait");
    endtask

    task automatic wait_tick();
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (aif.frame_tick === 1'b1) return;
        end
        timeout("tick_wait");
    endtask

    task automatic pop_exp(output logic [15:0] e);
        if (exp_q.size() == 0) begin
            timeout("scoreboard_empty");
            e = 16'hxxxx;
        end else e = exp_q.pop_front();
    endtask

    // Entered just after frame_tick (slot 0, BCLK low); samples DACDAT at each BCLK rise.
    task automatic frame_check(input string tag, input int chg_slot, input logic [15:0] ns, input logic nm);
        logic [15:0] l, r, e;
        int zbad, lbad;
        l = '0;
        r = '0;
        zbad = 0;
        lbad = 0;
        for (int s = 0; s < 64; s++) begin
            wait_bclk(1'b1);
            if (s >= 1 && s <= 16) l[16-s] = aif.AUD_DACDAT;
            else if (s >= 33 && s <= 48) r[48-s] = aif.AUD_DACDAT;
            else if (aif.AUD_DACDAT !== 1'b0) zbad++;
            if (aif.AUD_DACLRCK !== (s >= 32)) lbad++;
            if (s == chg_slot) begin
                aif.sample_in = ns;
                aif.mute = nm;
            end
            if (s < 63) wait_bclk(1'b0);
        end
        pop_exp(e);
        chk({tag, "_left"}, 32'(l), 32'(e));
        chk({tag, "_right"}, 32'(r), 32'(e));
        chk({tag, "_zero_slots"}, 32'(zbad), 0);
        chk({tag, "_lrck"}, 32'(lbad), 0);
    endtask

    task automatic reset_seq(input logic [15:0] s);
        int n, first_rise;
        logic dat_seen;
        resetn = 1'b0;
        aif.sample_in = s;
        aif.volume_shift = 3'd0;
        aif.mute = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_bclk", 32'(aif.AUD_BCLK), 0);
        chk("rst_lrck", 32'(aif.AUD_DACLRCK), 0);
        chk("rst_dat", 32'(aif.AUD_DACDAT), 0);
        chk("rst_tick", 32'(aif.frame_tick), 0);
        @(negedge clk);
        resetn = 1'b1;
        n = 0;
        first_rise = -1;
        dat_seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (aif.AUD_BCLK === 1'b1 && first_rise < 0) first_rise = n;
            dat_seen |= aif.AUD_DACDAT;
            if (aif.frame_tick === 1'b1) break;
        end
        chk("first_bclk_rise", 32'(first_rise), 8);
        chk("first_latch_cycles", 32'(n), 1024);
        chk("first_frame_zero", 32'(dat_seen), 0);
        chk("tick_lrck_low", 32'(aif.AUD_DACLRCK), 0);
    endtask

    initial begin
        logic [15:0] rs, e;
        logic [2:0] rv;
        int bclk_bad, lr_bad, tick_bad, ticks, last_rise, last_lr, last_tick;
        logic pb, pl;
        aif.sample_in = 16'h0000;
        aif.volume_shift = 3'd0;
        aif.mute = 1'b0;

        exp_q.push_back(16'hA5C3);
        reset_seq(16'hA5C3);
        frame_check("map_A5C3", -1, 16'h0, 1'b0);

        aif.sample_in = 16'h8000;
        aif.volume_shift = 3'd2;
        exp_q.push_back(16'hE000);
        wait_tick();
        frame_check("atten_8000_s2", -1, 16'h0, 1'b0);

        aif.sample_in = 16'h0004;
        aif.volume_shift = 3'd3;
        exp_q.push_back(16'h0000);
        wait_tick();
        frame_check("atten_0004_s3", -1, 16'h0, 1'b0);

        rs = 16'($urandom);
        rv = 3'($urandom_range(7, 0));
        aif.sample_in = rs;
        aif.volume_shift = rv;
        exp_q.push_back(atten(rs, rv, 1'b0));
        wait_tick();
        frame_check("atten_random", -1, 16'h0, 1'b0);

        aif.sample_in = 16'h1234;
        aif.volume_shift = 3'd0;
        exp_q.push_back(16'h1234);
        wait_tick();
        frame_check("midframe_hold", 20, 16'hFFFF, 1'b1);
        exp_q.push_back(16'h0000);
        wait_tick();
        frame_check("midframe_next", -1, 16'h0, 1'b0);

        wait_tick();
        bclk_bad = 0;
        lr_bad = 0;
        tick_bad = 0;
        ticks = 0;
        last_rise = -1;
        last_lr = 0;
        last_tick = 0;
        pb = aif.AUD_BCLK;
        pl = aif.AUD_DACLRCK;
        for (int c = 1; c <= 10240; c++) begin
            @(posedge clk);
            #1;
            if (aif.AUD_BCLK && !pb) begin
                if (last_rise >= 0 && c - last_rise != 16) bclk_bad++;
                last_rise = c;
            end
            if (aif.AUD_DACLRCK !== pl) begin
                if (c - last_lr != 512) lr_bad++;
                last_lr = c;
            end
            if (aif.frame_tick) begin
                if (c - last_tick != 1024) tick_bad++;
                last_tick = c;
                ticks++;
            end
            pb = aif.AUD_BCLK;
            pl = aif.AUD_DACLRCK;
        end
        chk("bclk_period", 32'(bclk_bad), 0);
        chk("lrck_half", 32'(lr_bad), 0);
        chk("tick_interval", 32'(tick_bad), 0);
        chk("tick_count", 32'(ticks), 10);

        aif.sample_in = 16'h7FFF;
        aif.mute = 1'b0;
        exp_q.push_back(16'h7FFF);
        wait_tick();
        for (int k = 0; k < 40; k++) begin
            wait_bclk(1'b1);
            wait_bclk(1'b0);
        end
        wait_bclk(1'b1);
        pop_exp(e);
        chk("slot40_dat", 32'(aif.AUD_DACDAT), 32'(e[8]));
        chk("slot40_lrck", 32'(aif.AUD_DACLRCK), 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_bclk", 32'(aif.AUD_BCLK), 0);
        chk("async_rst_lrck", 32'(aif.AUD_DACLRCK), 0);
        chk("async_rst_dat", 32'(aif.AUD_DACDAT), 0);

        exp_q.push_back(16'h5A5A);
        reset_seq(16'h5A5A);
        frame_check("map_after_reset", -1, 16'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
